// File: rtl/nbit_serial_tx.sv
// Parallel-in, serial-out framed transmitter: start bit 0, N data bits LSB
// first, stop bit 1, each held for CLKS_PER_BIT clocks behind a valid/ready load.
module nbit_serial_tx #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data_in,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         ser_out,
    output logic         busy,
    output logic         done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_nx;
    logic [N-1:0]  r_shift;
    logic [N-1:0]  w_shift_nx;
    logic          r_ser;
    logic          r_busy;
    logic          r_done;
    logic          w_ser_nx;
    logic          w_done_nx;
    logic          w_bit_end;
    logic          w_load;

    assign w_bit_end  = (r_cnt == CNT_LAST);
    assign load_ready = (r_state == S_IDLE) && !rst;
    assign w_load     = load_valid && load_ready;
    assign ser_out    = r_ser;
    assign busy       = r_busy;
    assign done       = r_done;

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_shift_nx = r_shift;
        w_done_nx  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_load) begin
                    w_shift_nx = data_in;
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_state_nx = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_idx_nx   = '0;
                    w_state_nx = S_DATA;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_shift_nx = r_shift >> 1;
                    if (r_idx == IDX_LAST) begin
                        w_state_nx = S_STOP;
                    end else begin
                        w_idx_nx = r_idx + 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b1;
                    w_state_nx = S_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Line level is registered from the upcoming state so it changes with the state.
    always_comb begin
        w_ser_nx = 1'b1;
        unique case (w_state_nx)
            S_START: w_ser_nx = 1'b0;
            S_DATA:  w_ser_nx = w_shift_nx[0];
            default: w_ser_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_ser   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_idx   <= w_idx_nx;
            r_shift <= w_shift_nx;
            r_ser   <= w_ser_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_done  <= w_done_nx;
        end
    end

endmodule

// File: tb/tb_nbit_serial_tx.sv
// Self-checking bench for nbit_serial_tx: a default 8-bit/4-clock instance and
// a 4-bit/1-clock corner instance, checked against a slot-based frame model.
module tb_nbit_serial_tx;

    logic       clk;
    logic       rst;
    logic [7:0] d1;
    logic       v1;
    logic       rdy1;
    logic       ser1;
    logic       busy1;
    logic       done1;
    logic [3:0] d2;
    logic       v2;
    logic       rdy2;
    logic       ser2;
    logic       busy2;
    logic       done2;

    int checks;
    int errors;

    nbit_serial_tx #(.N(8), .CLKS_PER_BIT(4)) dut1 (
        .clk(clk), .rst(rst), .data_in(d1), .load_valid(v1),
        .load_ready(rdy1), .ser_out(ser1), .busy(busy1), .done(done1)
    );

    nbit_serial_tx #(.N(4), .CLKS_PER_BIT(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(d2), .load_valid(v2),
        .load_ready(rdy2), .ser_out(ser2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected line level c cycles after the accepting edge (c = 1 is the first frame cycle).
    function automatic logic exp_ser(input logic [31:0] d, input int n,
                                     input int cpb, input int c);
        int slot;
        if (c < 1) return 1'b1;
        slot = (c - 1) / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= n) return d[slot-1];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int n, input int cpb, input int c);
        return (c >= 1) && (c <= (n + 2) * cpb);
    endfunction

    function automatic logic exp_done(input int n, input int cpb, input int c);
        return c == (n + 2) * cpb + 1;
    endfunction

    task automatic load1(input logic [7:0] d);
        @(negedge clk);
        v1 = 1'b1;
        d1 = d;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        d1 = ~d;
    endtask

    task automatic load2(input logic [3:0] d);
        @(negedge clk);
        v2 = 1'b1;
        d2 = d;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        d2 = ~d;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v1  = 1'b1;
        d1  = 8'hFF;
        v2  = 1'b1;
        d2  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1, rdy1, rdy2} !== 5'b10000) begin
                errors++;
                $display("FAIL reset cyc%0d ser/busy/done/rdy1/rdy2=%b want 10000",
                         i, {ser1, busy1, done1, rdy1, rdy2});
            end
        end
        v1  = 1'b0;
        v2  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({rdy1, rdy2, ser1, busy1} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_release rdy1/rdy2/ser/busy=%b want 1110",
                     {rdy1, rdy2, ser1, busy1});
        end
    endtask

    task automatic test_single_frame;
        load1(8'hA5);
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1} !== {exp_ser(32'hA5, 8, 4, c),
                 exp_busy(8, 4, c), exp_done(8, 4, c)}) begin
                errors++;
                $display("FAIL single c=%0d ser/busy/done=%b want %b", c,
                         {ser1, busy1, done1}, {exp_ser(32'hA5, 8, 4, c),
                         exp_busy(8, 4, c), exp_done(8, 4, c)});
            end
        end
    endtask

    task automatic test_ignored_load;
        load1(8'h3C);
        for (int c = 1; c <= 52; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1} !== {exp_ser(32'h3C, 8, 4, c),
                 exp_busy(8, 4, c), exp_done(8, 4, c)}) begin
                errors++;
                $display("FAIL ignored c=%0d ser/busy/done=%b want %b", c,
                         {ser1, busy1, done1}, {exp_ser(32'h3C, 8, 4, c),
                         exp_busy(8, 4, c), exp_done(8, 4, c)});
            end
            if (c >= 10 && c <= 12) begin
                v1 = 1'b1;
                d1 = 8'hFF;
                checks++;
                if (rdy1 !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored_ready c=%0d rdy=%b want 0", c, rdy1);
                end
            end else begin
                v1 = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        v1 = 1'b1;
        d1 = 8'h01;
        @(posedge clk);
        #1;
        d1 = 8'h80;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1, rdy1} !== {exp_ser(32'h01, 8, 4, c),
                 exp_busy(8, 4, c), exp_done(8, 4, c), c == 41}) begin
                errors++;
                $display("FAIL b2b_first c=%0d ser/busy/done/rdy=%b", c,
                         {ser1, busy1, done1, rdy1});
            end
        end
        @(posedge clk);
        #1;
        v1 = 1'b0;
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1} !== {exp_ser(32'h80, 8, 4, c),
                 exp_busy(8, 4, c), exp_done(8, 4, c)}) begin
                errors++;
                $display("FAIL b2b_second c=%0d ser/busy/done=%b want %b", c,
                         {ser1, busy1, done1}, {exp_ser(32'h80, 8, 4, c),
                         exp_busy(8, 4, c), exp_done(8, 4, c)});
            end
        end
    endtask

    task automatic test_mid_reset;
        load1(8'hF0);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            checks++;
            if (ser1 !== exp_ser(32'hF0, 8, 4, c)) begin
                errors++;
                $display("FAIL midrst_pre c=%0d ser=%b want %b", c, ser1,
                         exp_ser(32'hF0, 8, 4, c));
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ser1, busy1, done1, rdy1} !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_abort ser/busy/done/rdy=%b want 1000",
                     {ser1, busy1, done1, rdy1});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1} !== 3'b100) begin
                errors++;
                $display("FAIL midrst_idle c=%0d ser/busy/done=%b want 100",
                         c, {ser1, busy1, done1});
            end
        end
        load1(8'h55);
        for (int c = 1; c <= 41; c++) begin
            @(negedge clk);
            checks++;
            if ({ser1, busy1, done1} !== {exp_ser(32'h55, 8, 4, c),
                 exp_busy(8, 4, c), exp_done(8, 4, c)}) begin
                errors++;
                $display("FAIL midrst_after c=%0d ser/busy/done=%b", c,
                         {ser1, busy1, done1});
            end
        end
    endtask

    task automatic test_corner;
        logic [3:0] pat;
        pat = 4'b1001;
        for (int f = 0; f < 6; f++) begin
            load2(pat);
            for (int c = 1; c <= 8; c++) begin
                @(negedge clk);
                checks++;
                if ({ser2, busy2, done2} !== {exp_ser({28'd0, pat}, 4, 1, c),
                     exp_busy(4, 1, c), exp_done(4, 1, c)}) begin
                    errors++;
                    $display("FAIL corner d=%h c=%0d ser/busy/done=%b want %b",
                             pat, c, {ser2, busy2, done2},
                             {exp_ser({28'd0, pat}, 4, 1, c),
                             exp_busy(4, 1, c), exp_done(4, 1, c)});
                end
            end
            pat = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic test_random;
        logic [7:0] d;
        int         pc;
        for (int f = 0; f < 6; f++) begin
            d  = 8'($urandom);
            pc = int'($urandom_range(2, 38));
            load1(d);
            for (int c = 1; c <= 41; c++) begin
                @(negedge clk);
                checks++;
                if ({ser1, busy1, done1} !== {exp_ser({24'd0, d}, 8, 4, c),
                     exp_busy(8, 4, c), exp_done(8, 4, c)}) begin
                    errors++;
                    $display("FAIL random d=%h c=%0d ser/busy/done=%b want %b",
                             d, c, {ser1, busy1, done1},
                             {exp_ser({24'd0, d}, 8, 4, c),
                             exp_busy(8, 4, c), exp_done(8, 4, c)});
                end
                v1 = (c == pc);
                d1 = 8'($urandom);
            end
            v1 = 1'b0;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        v1     = 1'b0;
        d1     = 8'h00;
        v2     = 1'b0;
        d2     = 4'h0;
        test_reset;
        test_single_frame;
        test_ignored_load;
        test_back_to_back;
        test_mid_reset;
        test_corner;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nbit_serial_tx.md
Name: nbit_serial_tx

Overview:
- Parallel-in, serial-out transmitter for the N-bit register datapath.
- Accepts an N-bit word through a valid/ready handshake and captures it into an internal shift register.
- Drives the word onto a single line as a framed serial stream: start bit 0, then N data bits LSB first, then stop bit 1.
- This is the sending end of the serial link whose receiving end deserialises back into an N-bit register.

Parameters:
- N, 8, data word width in bits; N >= 1.
- CLKS_PER_BIT, 4, clock cycles each serial bit is held on ser_out; CLKS_PER_BIT >= 1.

Ports:
- clk  input  1  rising-edge system clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  N  word to transmit; sampled only on handshake.
- load_valid  input  1  data_in valid this cycle.
- load_ready  output  1  block can accept a word; high in IDLE and when rst is low.
- ser_out  output  1  serial line; idles high.
- busy  output  1  frame in progress (START, DATA or STOP).
- done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Reset is synchronous; rst is sampled on the rising clk edge. While rst is high:
  - state = IDLE, ser_out = 1, busy = 0, done = 0, load_ready = 0.
  - All counters and the shift register are cleared.
  - Reset mid-frame aborts the frame immediately; the line returns high on the next edge, with no done pulse.
- States: IDLE, START, DATA, STOP. All outputs are registered except load_ready = (state == IDLE) && !rst.
- Handshake: a word is accepted on a rising edge where load_valid && load_ready.
  - data_in is copied into the shift register; later changes to data_in have no effect.
  - Next state is START.
  - load_valid outside IDLE is ignored; there is no queuing.
- Bit timing: a divide counter (width clog2(CLKS_PER_BIT), minimum 1) counts 0..CLKS_PER_BIT-1. Each bit lasts exactly CLKS_PER_BIT cycles.
- START: ser_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - ser_out = shift register bit 0.
  - At the end of each bit period, shift right by 1 and increment the bit index (width clog2(N), minimum 1).
  - After bit N-1 completes, go to STOP.
- STOP: ser_out = 1 for CLKS_PER_BIT cycles, then go to IDLE and assert done for exactly that first IDLE cycle.
- busy = 1 in START, DATA and STOP; 0 in IDLE.
- Latency and frame length:
  - If accepted at edge k, the start bit occupies cycles k+1 .. k+CLKS_PER_BIT.
  - The frame occupies (N+2)*CLKS_PER_BIT cycles; done is high in cycle k+(N+2)*CLKS_PER_BIT+1.
- Back-to-back: a load accepted during the done cycle is legal. The new frame starts on the next cycle, with the line low (start bit) immediately after that cycle's ser_out = 1. The minimum gap between frames is one idle-high cycle.
- CLKS_PER_BIT = 1: one cycle per bit; the counter never advances beyond 0.
- N = 1: DATA lasts exactly one bit period.
- Simultaneous rst and load_valid: reset wins and the word is not accepted.

Test Plan:
- Reset: N=8, CLKS_PER_BIT=4; hold rst 3 cycles → ser_out=1, busy=0, done=0, load_ready=0. Deassert → load_ready=1 on the next cycle.
- Single frame: load 8'hA5 at edge k → ser_out=0 for k+1..k+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each (k+5..k+36), then 1 for k+37..k+40. done=1 only at k+41; busy=1 for k+1..k+40.
- Ignored load: during the frame of 8'h3C, pulse load_valid with 8'hFF → load_ready=0, the frame completes unchanged as 0,0,0,1,1,1,1,0,0,1 (4 cycles each), and no second frame follows.
- Back-to-back: with load_valid held high and data 8'h01 then 8'h80, the second word is accepted in the done cycle → exactly one idle-high cycle between frames, second frame data bits 0,0,0,0,0,0,0,1.
- Mid-frame reset: assert rst during data bit 3 of 8'hF0 → ser_out=1 and busy=0 on the next edge, done never pulses. After release, 8'h55 transmits correctly.
- Parameter corner: N=4, CLKS_PER_BIT=1, load 4'b1001 → ser_out sequence 0,1,0,0,1,1 over 6 cycles, done at cycle 7.
